// File: rtl/avg_seq_pkg.sv
// Shared types, default widths and saturation limits for the time-multiplexed
// average-of-N sequencer.
package avg_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DIVIDE = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  localparam int DEF_DATAWIDTH   = 16;
  localparam int DEF_NUM_SAMPLES = 8;
  localparam int DEF_ACCWIDTH    = 32;

  // Largest value representable in a dw-bit signed result.
  function automatic logic signed [63:0] sat_hi(input int dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a dw-bit signed result.
  function automatic logic signed [63:0] sat_lo(input int dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Signed restoring divider: one setup cycle then one quotient bit per cycle.
// Quotient truncates toward zero; done_o marks the cycle whose edge yields quotient_o.
module seq_divider #(
  parameter int ACCWIDTH  = 32,
  parameter int DATAWIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic signed [ACCWIDTH-1:0]  dividend_i,
  input  logic signed [DATAWIDTH-1:0] divisor_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic signed [ACCWIDTH-1:0]  quotient_o
);

  localparam int CW = $clog2(ACCWIDTH);

  logic                 busy_q;
  logic [CW-1:0]        cnt_q;
  logic [DATAWIDTH-1:0] rem_q;
  logic [ACCWIDTH-1:0]  quo_q;
  logic [DATAWIDTH:0]   dvs_q;
  logic                 neg_q;

  logic [DATAWIDTH:0]   shifted_s;
  logic                 fits_s;
  logic [DATAWIDTH-1:0] rem_d;
  logic [ACCWIDTH-1:0]  quo_d;
  logic [ACCWIDTH-1:0]  dividend_mag_s;
  logic [DATAWIDTH:0]   divisor_ext_s;
  logic [DATAWIDTH:0]   divisor_mag_s;

  // One restoring step plus operand magnitudes for the setup cycle.
  always_comb begin
    shifted_s      = {rem_q, quo_q[ACCWIDTH-1]};
    fits_s         = (shifted_s >= dvs_q);
    rem_d          = fits_s ? DATAWIDTH'(shifted_s - dvs_q) : shifted_s[DATAWIDTH-1:0];
    quo_d          = {quo_q[ACCWIDTH-2:0], fits_s};
    dividend_mag_s = dividend_i[ACCWIDTH-1] ? ACCWIDTH'(-dividend_i) : ACCWIDTH'(dividend_i);
    divisor_ext_s  = {divisor_i[DATAWIDTH-1], divisor_i};
    divisor_mag_s  = divisor_ext_s[DATAWIDTH] ? -divisor_ext_s : divisor_ext_s;
    done_o         = busy_q && (cnt_q == CW'(ACCWIDTH - 1));
    quotient_o     = neg_q ? -quo_d : quo_d;
  end

  assign busy_o = busy_q;

  // Setup on start, then shift in one quotient bit per cycle until done.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      cnt_q  <= {CW{1'b0}};
      rem_q  <= {DATAWIDTH{1'b0}};
      quo_q  <= {ACCWIDTH{1'b0}};
      dvs_q  <= {(DATAWIDTH + 1){1'b0}};
      neg_q  <= 1'b0;
    end else if (start_i && !busy_q) begin
      busy_q <= 1'b1;
      cnt_q  <= {CW{1'b0}};
      rem_q  <= {DATAWIDTH{1'b0}};
      quo_q  <= dividend_mag_s;
      dvs_q  <= divisor_mag_s;
      neg_q  <= dividend_i[ACCWIDTH-1] ^ divisor_i[DATAWIDTH-1];
    end else if (busy_q) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_q + CW'(1);
      busy_q <= !done_o;
    end else begin
      busy_q <= busy_q;
    end
  end

endmodule

// File: rtl/avg_sequencer.sv
// Averages NUM_SAMPLES signed samples with one adder and an iterative divider,
// presenting a saturated signed result over a valid/ready handshake.
module avg_sequencer
  import avg_seq_pkg::*;
#(
  parameter int DATAWIDTH   = DEF_DATAWIDTH,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int ACCWIDTH    = DEF_ACCWIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [DATAWIDTH-1:0] num,
  output logic                        busy,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DATAWIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DATAWIDTH-1:0] avg,
  output logic                        div_zero
);

  localparam int CNTW = $clog2(NUM_SAMPLES);
  localparam logic signed [63:0]          Q_HI   = sat_hi(DATAWIDTH);
  localparam logic signed [63:0]          Q_LO   = sat_lo(DATAWIDTH);
  localparam logic signed [DATAWIDTH-1:0] AVG_HI = Q_HI[DATAWIDTH-1:0];
  localparam logic signed [DATAWIDTH-1:0] AVG_LO = Q_LO[DATAWIDTH-1:0];

  state_e                      state_q;
  logic signed [ACCWIDTH-1:0]  acc_q;
  logic signed [ACCWIDTH-1:0]  acc_d;
  logic [CNTW-1:0]             cnt_q;
  logic signed [DATAWIDTH-1:0] num_q;
  logic signed [DATAWIDTH-1:0] avg_q;
  logic signed [DATAWIDTH-1:0] avg_d;
  logic                        div_zero_q;
  logic                        out_valid_q;
  logic                        in_ready_q;
  logic                        busy_q;

  logic                        div_start_s;
  logic                        div_busy_s;
  logic                        div_done_s;
  logic signed [ACCWIDTH-1:0]  quot_s;
  logic signed [63:0]          quot_wide_s;

  seq_divider #(
    .ACCWIDTH  (ACCWIDTH),
    .DATAWIDTH (DATAWIDTH)
  ) u_div (
    .clk_i      (clk),
    .rst_ni     (rst),
    .start_i    (div_start_s),
    .dividend_i (acc_q),
    .divisor_i  (num_q),
    .busy_o     (div_busy_s),
    .done_o     (div_done_s),
    .quotient_o (quot_s)
  );

  // Accumulator next value, divider kick-off and result saturation.
  always_comb begin
    acc_d       = acc_q + {{(ACCWIDTH - DATAWIDTH){in_data[DATAWIDTH-1]}}, in_data};
    div_start_s = (state_q == DIVIDE) && !div_busy_s;
    quot_wide_s = 64'(quot_s);
    if (quot_wide_s > Q_HI) begin
      avg_d = AVG_HI;
    end else if (quot_wide_s < Q_LO) begin
      avg_d = AVG_LO;
    end else begin
      avg_d = quot_s[DATAWIDTH-1:0];
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= {ACCWIDTH{1'b0}};
      cnt_q       <= {CNTW{1'b0}};
      num_q       <= {DATAWIDTH{1'b0}};
      avg_q       <= {DATAWIDTH{1'b0}};
      div_zero_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACCUM;
            num_q      <= num;
            acc_q      <= {ACCWIDTH{1'b0}};
            cnt_q      <= {CNTW{1'b0}};
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_q <= acc_d;
            if (cnt_q == CNTW'(NUM_SAMPLES - 1)) begin
              in_ready_q <= 1'b0;
              if (num_q == {DATAWIDTH{1'b0}}) begin
                state_q     <= OUTPUT;
                avg_q       <= {DATAWIDTH{1'b0}};
                div_zero_q  <= 1'b1;
                out_valid_q <= 1'b1;
              end else begin
                state_q <= DIVIDE;
              end
            end else begin
              cnt_q <= cnt_q + CNTW'(1);
            end
          end
        end
        DIVIDE: begin
          if (div_done_s) begin
            state_q     <= OUTPUT;
            avg_q       <= avg_d;
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign avg       = avg_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_avg_sequencer.sv
// Directed bench for avg_sequencer with hand-computed averages and latencies.
module tb_avg_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [15:0] num;
  logic               busy;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] avg;
  logic               div_zero;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic signed [15:0] smp [8];

  avg_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num       (num),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .avg       (avg),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic fill(input int base, input int step);
    for (int i = 0; i < 8; i++) smp[i] = 16'(base + step * i);
  endtask

  // Present start for one edge; edge numbering treats that edge as edge 1.
  task automatic begin_run(input logic signed [15:0] n);
    @(negedge clk);
    start = 1'b1;
    num   = n;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    num   = 16'sh7f7f;
  endtask

  task automatic feed(input bit gaps);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = smp[i];
      @(posedge clk);
      if (gaps) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'sh5555;
        @(posedge clk);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int max, output int lat, output bit ok);
    ok  = 1'b0;
    lat = -1;
    for (int i = 0; i < max; i++) begin
      if (out_valid) begin
        ok  = 1'b1;
        lat = cyc - start_cyc + 1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_avg(input logic signed [15:0] n, input bit gaps, output int lat, output bit ok);
    begin_run(n);
    feed(gaps);
    wait_out(200, lat, ok);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; num = 16'sd0; in_valid = 1'b0; in_data = 16'sd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, in_ready, out_valid, div_zero} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000", {busy, in_ready, out_valid, div_zero});
    end
    checks++;
    if (avg !== 16'sd0) begin
      errors++;
      $display("FAIL reset_avg got %0d exp 0", avg);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int lat; bit ok;
    fill(1, 1);
    out_ready = 1'b1;
    run_avg(16'sd8, 1'b0, lat, ok);
    checks++;
    if (!ok || lat !== 42) begin
      errors++;
      $display("FAIL basic_latency got %0d exp 42", lat);
    end
    checks++;
    if (avg !== 16'sd4 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL basic_avg got %0d/%b exp 4/0", avg, div_zero);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_in_ready got %b exp 0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_return_idle got %b%b exp 00", out_valid, busy);
    end
  endtask

  task automatic test_signed_table(input bit sat);
    int base [3]; int step [3]; int nn [3]; int exp_avg [3]; int cnt;
    int lat; bit ok;
    if (sat) begin
      base = '{32767, -32768, 32767}; step = '{0, 0, 0};
      nn = '{1, -1, -1}; exp_avg = '{32767, 32767, -32768}; cnt = 3;
    end else begin
      base = '{-1, -32768, 0}; step = '{-1, 0, 0};
      nn = '{8, 8, 1}; exp_avg = '{-4, -32768, 0}; cnt = 2;
    end
    out_ready = 1'b1;
    for (int k = 0; k < cnt; k++) begin
      fill(base[k], step[k]);
      run_avg(16'(nn[k]), 1'b0, lat, ok);
      checks++;
      if (!ok || lat !== 42 || avg !== 16'(exp_avg[k]) || div_zero !== 1'b0) begin
        errors++;
        $display("FAIL signed_case%0d_sat%0d got avg %0d lat %0d dz %b exp avg %0d lat 42 dz 0",
                 k, sat, avg, lat, div_zero, exp_avg[k]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_div_zero();
    int lat; bit ok;
    fill(1, 1);
    out_ready = 1'b1;
    run_avg(16'sd0, 1'b0, lat, ok);
    checks++;
    if (!ok || lat !== 9) begin
      errors++;
      $display("FAIL dz_latency got %0d exp 9", lat);
    end
    checks++;
    if (avg !== 16'sd0 || div_zero !== 1'b1) begin
      errors++;
      $display("FAIL dz_result got %0d/%b exp 0/1", avg, div_zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL dz_drop got %b exp 0", out_valid);
    end
  endtask

  task automatic test_in_gaps();
    int lat; bit ok;
    fill(1, 1);
    out_ready = 1'b1;
    run_avg(16'sd8, 1'b1, lat, ok);
    checks++;
    if (!ok || lat !== 49 || avg !== 16'sd4 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL gaps got avg %0d lat %0d dz %b exp 4 49 0", avg, lat, div_zero);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_out_stall();
    int lat; bit ok;
    fill(1, 1);
    out_ready = 1'b0;
    run_avg(16'sd8, 1'b0, lat, ok);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || avg !== 16'sd4 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d got ov %b avg %0d ir %b exp 1 4 0", c, out_valid, avg, in_ready);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got %b exp 0", out_valid);
    end
  endtask

  task automatic test_start_ignored();
    int lat; bit ok;
    fill(1, 1);
    out_ready = 1'b0;
    begin_run(16'sd8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = smp[i];
      start    = (i == 3);
      num      = 16'sd0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    wait_out(200, lat, ok);
    checks++;
    if (!ok || lat !== 42 || avg !== 16'sd4 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored_result got avg %0d lat %0d dz %b exp 4 42 0", avg, lat, div_zero);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_on_accept got busy %b ov %b exp 0 0", busy, out_valid);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat; bit ok; int seen;
    fill(1, 1);
    out_ready = 1'b1;
    begin_run(16'sd8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = smp[i];
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, in_ready, out_valid, div_zero} !== 4'b0000 || avg !== 16'sd0) begin
      errors++;
      $display("FAIL midreset_clear got %b avg %0d exp 0000 avg 0", {busy, in_ready, out_valid, div_zero}, avg);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_no_partial got %0d active cycles exp 0", seen);
    end
    fill(10, 0);
    run_avg(16'sd8, 1'b0, lat, ok);
    checks++;
    if (!ok || lat !== 42 || avg !== 16'sd10) begin
      errors++;
      $display("FAIL midreset_rerun got avg %0d lat %0d exp 10 42", avg, lat);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed_table(1'b0);
    test_signed_table(1'b1);
    test_div_zero();
    test_in_gaps();
    test_out_stall();
    test_start_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
